// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared states, opcodes, IR field positions and opcode classifiers
package cpu_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;
  function automatic logic is_muldiv(input logic [4:0] op);
    return op == OP_MUL || op == OP_DIV;
  endfunction
  function automatic logic is_alu(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR} || is_muldiv(op);
  endfunction
endpackage

// File: rtl/reg_sel_decoder.sv
// reg_sel_decoder: 4-bit register field to one-hot select with enable
module reg_sel_decoder #(
  parameter int NREGS = 16
) (
  input  logic [3:0]       sel,
  input  logic             en,
  output logic [NREGS-1:0] onehot
);
  assign onehot = en ? ((NREGS)'(1) << sel) : '0;
endmodule

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: Moore control FSM for fetch and register-to-register ALU execution
module alu_instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Run,
  input  logic [31:0]      IR,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             ZLowIn,
  output logic             ZHighIn,
  output logic             Zlowout,
  output logic             ZHighout,
  output logic             HIin,
  output logic             LOin,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic [4:0]       alu_op,
  output logic             Halted,
  output logic             Busy
);
  state_t state, nxt, eoi;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic md, unused_ir;
  logic [NREGS-1:0] rin_d, rout_d;
  assign op = IR[OP_HI:OP_LO];
  assign ra = IR[RA_HI:RA_LO];
  assign rb = IR[RB_HI:RB_LO];
  assign rc = IR[RC_HI:RC_LO];
  assign unused_ir = ^IR[RC_LO-1:0];
  assign md = is_muldiv(op);
  assign eoi = Run ? S_T0 : S_IDLE;
  // next-state decode; Run only matters in IDLE and at end of instruction
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE: nxt = Run ? S_T0 : S_IDLE;
      S_T0:   nxt = S_T1;
      S_T1:   nxt = S_T2;
      S_T2:   nxt = S_T3;
      S_T3:   nxt = is_alu(op) ? S_T4 : (op == OP_HALT ? S_HALT : eoi);
      S_T4:   nxt = S_T5;
      S_T5:   nxt = md ? S_T6 : eoi;
      S_T6:   nxt = eoi;
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
  end
  reg_sel_decoder #(.NREGS(NREGS)) u_rin (
    .sel(ra),
    .en(nxt == S_T5 && !md),
    .onehot(rin_d)
  );
  reg_sel_decoder #(.NREGS(NREGS)) u_rout (
    .sel(nxt == S_T3 ? rb : rc),
    .en(nxt == S_T3 || nxt == S_T4),
    .onehot(rout_d)
  );
  // state register plus strobes decoded from the next state, so each is high for its whole state
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state    <= S_IDLE;
      PCout    <= 1'b0;
      MARin    <= 1'b0;
      IncPC    <= 1'b0;
      PCin     <= 1'b0;
      Read     <= 1'b0;
      MDRin    <= 1'b0;
      MDRout   <= 1'b0;
      IRin     <= 1'b0;
      Yin      <= 1'b0;
      ZLowIn   <= 1'b0;
      ZHighIn  <= 1'b0;
      Zlowout  <= 1'b0;
      ZHighout <= 1'b0;
      HIin     <= 1'b0;
      LOin     <= 1'b0;
      Rin      <= '0;
      Rout     <= '0;
      alu_op   <= '0;
      Halted   <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      state    <= nxt;
      PCout    <= nxt == S_T0;
      MARin    <= nxt == S_T0;
      IncPC    <= nxt == S_T0;
      PCin     <= nxt == S_T1;
      Read     <= nxt == S_T1;
      MDRin    <= nxt == S_T1;
      MDRout   <= nxt == S_T2;
      IRin     <= nxt == S_T2;
      Yin      <= nxt == S_T3;
      ZLowIn   <= nxt == S_T0 || nxt == S_T4;
      ZHighIn  <= nxt == S_T4 && md;
      Zlowout  <= nxt == S_T1 || nxt == S_T5;
      ZHighout <= nxt == S_T6;
      HIin     <= nxt == S_T6;
      LOin     <= nxt == S_T5 && md;
      Rin      <= rin_d;
      Rout     <= rout_d;
      alu_op   <= nxt == S_T4 ? op : 5'd0;
      Halted   <= nxt == S_HALT;
      Busy     <= nxt != S_IDLE && nxt != S_HALT;
    end
  end
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer: directed per-cycle checks of the control sequencer
module tb_alu_instr_sequencer;
  logic Clock, Clear, Run;
  logic [31:0] IR;
  logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin, Halted, Busy;
  logic [15:0] Rin, Rout;
  logic [4:0] alu_op;
  logic [14:0] strb;
  logic [53:0] obs;
  int vecs = 0;
  int errs = 0;
  localparam logic [14:0] ST_T0  = 15'b111_000_000_100_000;
  localparam logic [14:0] ST_T1  = 15'b000_111_000_001_000;
  localparam logic [14:0] ST_T2  = 15'b000_000_110_000_000;
  localparam logic [14:0] ST_T3  = 15'b000_000_001_000_000;
  localparam logic [14:0] ST_T4  = 15'b000_000_000_100_000;
  localparam logic [14:0] ST_T4M = 15'b000_000_000_110_000;
  localparam logic [14:0] ST_T5  = 15'b000_000_000_001_000;
  localparam logic [14:0] ST_T5M = 15'b000_000_000_001_001;
  localparam logic [14:0] ST_T6  = 15'b000_000_000_000_110;
  localparam logic [53:0] W_T0 = {ST_T0, 32'h0, 5'h0, 2'b01};
  localparam logic [53:0] W_T1 = {ST_T1, 32'h0, 5'h0, 2'b01};
  localparam logic [53:0] W_T2 = {ST_T2, 32'h0, 5'h0, 2'b01};
  localparam logic [53:0] W_HALT = 54'h2;
  assign strb = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
                 ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin};
  assign obs = {strb, Rin, Rout, alu_op, Halted, Busy};

  alu_instr_sequencer #(.NREGS(16)) dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn),
    .ZHighIn(ZHighIn), .Zlowout(Zlowout), .ZHighout(ZHighout), .HIin(HIin),
    .LOin(LOin), .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .Halted(Halted), .Busy(Busy)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // at most one source may drive the shared bus in any cycle
  always @(negedge Clock) begin
    if (Clear === 1'b1) begin
      vecs++;
      if (int'(PCout) + int'(Zlowout) + int'(MDRout) + $countones(Rout) > 1) begin
        errs++;
        $display("FAIL bus_conflict @%0t: PCout=%b Zlowout=%b MDRout=%b Rout=%h, want at most one driver",
                 $time, PCout, Zlowout, MDRout, Rout);
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Clear = 1'b0; Run = 1'b0; IR = 32'h0;
    tick();
    tick();
    vecs++;
    if (obs !== 54'h0) begin errs++; $display("FAIL reset_hold: got %h want %h", obs, 54'h0); end
    Clear = 1'b1;
    tick();
    tick();
    vecs++;
    if (obs !== 54'h0) begin errs++; $display("FAIL reset_idle: got %h want %h", obs, 54'h0); end
  endtask

  task automatic test_or();
    logic [53:0] e [7];
    e = '{W_T0, W_T1, W_T2,
          {ST_T3, 16'h0, 16'h0004, 5'h0, 2'b01},
          {ST_T4, 16'h0, 16'h0010, 5'b01011, 2'b01},
          {ST_T5, 16'h0020, 16'h0, 5'h0, 2'b01},
          54'h0};
    IR = 32'h5A920000; Run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      vecs++;
      if (obs !== e[i]) begin errs++; $display("FAIL or[%0d]: got %h want %h", i, obs, e[i]); end
      if (i == 5) Run = 1'b0;
    end
  endtask

  task automatic test_muldiv(input logic [4:0] op);
    logic [53:0] e [8];
    e = '{W_T0, W_T1, W_T2,
          {ST_T3, 16'h0, 16'h0008, 5'h0, 2'b01},
          {ST_T4M, 16'h0, 16'h0040, op, 2'b01},
          {ST_T5M, 16'h0, 16'h0, 5'h0, 2'b01},
          {ST_T6, 16'h0, 16'h0, 5'h0, 2'b01},
          54'h0};
    IR = {op, 4'd1, 4'd3, 4'd6, 15'd0}; Run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      vecs++;
      if (obs !== e[i]) begin errs++; $display("FAIL muldiv_%b[%0d]: got %h want %h", op, i, obs, e[i]); end
      if (i == 6) Run = 1'b0;
    end
  endtask

  task automatic test_run_drop();
    logic [53:0] e [15];
    logic [53:0] a3, a4, a5;
    a3 = {ST_T3, 16'h0, 16'h0001, 5'h0, 2'b01};
    a4 = {ST_T4, 16'h0, 16'h0001, 5'b00011, 2'b01};
    a5 = {ST_T5, 16'h0001, 16'h0, 5'h0, 2'b01};
    e = '{W_T0, W_T1, W_T2, a3, a4, a5, 54'h0, 54'h0,
          W_T0, W_T1, W_T2, a3, a4, a5, 54'h0};
    IR = 32'h1800_0000; Run = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      vecs++;
      if (obs !== e[i]) begin errs++; $display("FAIL run_drop[%0d]: got %h want %h", i, obs, e[i]); end
      if (i == 2 || i == 8) Run = 1'b0;
      if (i == 7) Run = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic [53:0] e [11];
    e = '{W_T0, W_T1, W_T2,
          {ST_T3, 16'h0, 16'h0080, 5'h0, 2'b01},
          W_T0, W_T1, W_T2,
          {ST_T3, 16'h0, 16'h0004, 5'h0, 2'b01},
          {ST_T4, 16'h0, 16'h0010, 5'b01011, 2'b01},
          {ST_T5, 16'h0020, 16'h0, 5'h0, 2'b01},
          54'h0};
    IR = {5'b11010, 4'd0, 4'd7, 4'd0, 15'd0}; Run = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      vecs++;
      if (obs !== e[i]) begin errs++; $display("FAIL back_to_back[%0d]: got %h want %h", i, obs, e[i]); end
      if (i == 4) IR = 32'h5A920000;
      if (i == 9) Run = 1'b0;
    end
  endtask

  task automatic test_halt();
    logic [53:0] e [10];
    e = '{W_T0, W_T1, W_T2,
          {ST_T3, 16'h0, 16'h0200, 5'h0, 2'b01},
          W_HALT, W_HALT, W_HALT, W_HALT, W_HALT, W_HALT};
    IR = {5'b11011, 4'd0, 4'd9, 4'd0, 15'd0}; Run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vecs++;
      if (obs !== e[i]) begin errs++; $display("FAIL halt[%0d]: got %h want %h", i, obs, e[i]); end
      if (i >= 4) Run = i[0];
    end
    #2 Clear = 1'b0;
    #1;
    vecs++;
    if (obs !== 54'h0) begin errs++; $display("FAIL halt_clear: got %h want %h", obs, 54'h0); end
    Run = 1'b0;
    tick();
    Clear = 1'b1;
    tick();
    vecs++;
    if (obs !== 54'h0) begin errs++; $display("FAIL halt_release: got %h want %h", obs, 54'h0); end
  endtask

  task automatic test_async_clear();
    IR = 32'h5A920000; Run = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    vecs++;
    if (obs !== {ST_T4, 16'h0, 16'h0010, 5'b01011, 2'b01}) begin
      errs++; $display("FAIL clear_pre_t4: got %h want %h", obs, {ST_T4, 16'h0, 16'h0010, 5'b01011, 2'b01});
    end
    #2 Clear = 1'b0;
    #1;
    vecs++;
    if (obs !== 54'h0) begin errs++; $display("FAIL clear_async: got %h want %h", obs, 54'h0); end
    Run = 1'b0;
    tick();
    Clear = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++;
      if (obs !== 54'h0) begin errs++; $display("FAIL clear_idle[%0d]: got %h want %h", i, obs, 54'h0); end
    end
    Run = 1'b1;
    tick();
    vecs++;
    if (obs !== W_T0) begin errs++; $display("FAIL clear_restart: got %h want %h", obs, W_T0); end
    Run = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    vecs++;
    if (obs !== 54'h0) begin errs++; $display("FAIL clear_restart_idle: got %h want %h", obs, 54'h0); end
  endtask

  initial begin
    test_reset();
    test_or();
    test_muldiv(5'b01111);
    test_muldiv(5'b10000);
    test_run_drop();
    test_back_to_back();
    test_halt();
    test_async_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/alu_instr_sequencer.md
# alu_instr_sequencer

Hard-wired control sequencer that sits directly upstream of the single-bus CPU datapath (`CPUproject`). It generates, cycle by cycle, the datapath control strobes for instruction fetch (T0–T2) and for execution of register-to-register ALU instructions (T3–T5, plus T6 for mul/div). This replaces hand-driven strobes with a Moore FSM that decodes the IR.

## Interface
Parameters:
- `NREGS`, 16, number of general registers; width of the one-hot `Rin`/`Rout` buses.

Ports:
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Clear`  in  1  asynchronous, active-low reset.
- `Run`  in  1  level; start or continue instruction execution.
- `IR`  in  32  instruction register contents from the datapath. Fields: op[31:27], Ra[26:23], Rb[22:19], Rc[18:15].
- `PCout`, `MARin`, `IncPC`, `PCin`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`, `ZLowIn`, `ZHighIn`, `Zlowout`, `ZHighout`, `HIin`, `LOin`  out  1 each  datapath strobes.
- `Rin`  out  NREGS  one-hot register load enable.
- `Rout`  out  NREGS  one-hot register bus drive.
- `alu_op`  out  5  ALU operation code; equals IR op during T4, otherwise 0.
- `Halted`  out  1  sticky; high in HALT state.
- `Busy`  out  1  high in every state except IDLE and HALT.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
- All outputs are registered and decoded from the next state, so each strobe is high for exactly the full clock period of its state.
- Per-state strobes (all others 0):
  - T0: PCout, MARin, IncPC, ZLowIn.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], alu_op=op, ZLowIn; ZHighIn additionally for MUL/DIV.
  - T5: Zlowout, plus Rin[Ra] for ALU ops or LOin for MUL/DIV.
  - T6: ZHighout, HIin.
- Transitions:
  - IDLE→T0 when Run=1.
  - T0→T1→T2→T3.
  - At T3, decode op:
    - ALU set → T4.
    - HALT → HALT.
    - Anything else (NOP/unsupported) → end-of-instruction.
  - T4→T5.
  - At T5: MUL/DIV → T6; otherwise end-of-instruction.
  - T6 → end-of-instruction.
  - End-of-instruction: Run=1 → T0, Run=0 → IDLE.
  - HALT exits only on Clear.
- The IR fields used in T3–T6 are taken from the `IR` input. The IR is stable after T2, so no internal copy is kept.
- Ra = Rb = Rc is legal. Ra=0 still writes R0.
- `Run` is sampled only in IDLE and at end-of-instruction; deassertion mid-instruction completes the current instruction.

## Timing
- Clear low (any time, including mid-instruction): state→IDLE and all outputs→0 immediately (asynchronous). Halted=0.
- Clear released: first Run=1 edge enters T0; PCout high the following cycle.
- Latency per instruction:
  - ALU: 6 cycles (T0–T5).
  - MUL/DIV: 7 cycles.
  - NOP: 4 cycles.
  - HALT: enters HALT after 4 cycles.
- Back-to-back instructions: T5 (or T6, or T3 for NOP) is followed directly by T0, with no bubble.
- Read/MDRin are single-cycle; memory must return data within the T1 cycle.

## Structure
- Package `cpu_ctrl_pkg`:
  - State enum.
  - Opcode constants: ADD 00011, SUB 00100, SHR 00101, SHL 00111, ROR 01000, ROL 01001, AND 01010, OR 01011, MUL 01111, DIV 10000, NOP 11010, HALT 11011.
  - IR field bit positions.
  - `is_alu(op)` and `is_muldiv(op)` functions.
- Sub-module `reg_sel_decoder`: 4-bit field → NREGS one-hot, with enable. Instantiated twice, once for Rin and once for Rout; Rout selects Rb in T3 and Rc in T4.

## Test plan
- Reset: drive Clear=0 during T4 → all outputs 0 immediately and state IDLE. Release with Run=0 → remains IDLE, Busy=0.
- OR instruction, IR=0x5A920000 (op 01011, Ra=5, Rb=2, Rc=4), Run=1:
  - T3: Rout=0x0004, Yin=1.
  - T4: Rout=0x0010, alu_op=01011, ZLowIn=1.
  - T5: Rin=0x0020, Zlowout=1.
  - Next cycle: T0.
- MUL, op 01111, Rb=3, Rc=6:
  - T4: ZLowIn=ZHighIn=1.
  - T5: LOin=1, Rin=0.
  - T6: HIin=1, ZHighout=1.
  - Total 7 cycles.
- Run dropped during T2 → instruction completes through T5, then IDLE. Run re-asserted → T0 next cycle.
- NOP (11010): T3→T0 with no Rin or alu_op activity. HALT (11011): Halted=1 and sticky; Run toggling ignored until Clear.
- Fetch strobes: each of PCout/MARin/IncPC/ZLowIn (T0), Zlowout/PCin/Read/MDRin (T1), MDRout/IRin (T2) is high exactly one cycle, and no two strobes drive the bus (PCout, Zlowout, MDRout, Rout) simultaneously.
